// File: rtl/register_file_mp_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Imported by the interface, the scoreboard and the top level.
package register_file_mp_pkg;

    localparam int NUM_REGS = 32;
    localparam int WORD_W   = 32;

    typedef logic [WORD_W-1:0]            word_t;
    typedef logic [$clog2(NUM_REGS)-1:0]  regbits_t;

    // Register 0 is hardwired to zero.
    // Selects at or above nregs only exist when nregs is not a power of two.
    function automatic logic sel_writable(input int sel, input int nregs);
        return (sel != 0) && (sel < nregs);
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus between decode/issue/write-back and the register file.
// The master drives selects, data and control; the slave returns read data and busy state.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int NREGS  = NUM_REGS,
    parameter int DW     = $bits(word_t),
    parameter int AW     = $clog2(NREGS)
) ();

    logic [NWRITE-1:0]    wen;
    logic [NWRITE*AW-1:0] wsel;
    logic [NWRITE*DW-1:0] wdat;
    logic [NREAD*AW-1:0]  rsel;
    logic [NREAD*DW-1:0]  rdat;
    logic [NREAD-1:0]     rbusy;
    logic                 issue_en;
    logic [AW-1:0]        issue_rd;
    logic                 flush;
    logic [NREGS-1:0]     busy_vec;

    modport master (
        output wen, wsel, wdat, rsel, issue_en, issue_rd, flush,
        input  rdat, rbusy, busy_vec
    );

    modport slave (
        input  wen, wsel, wdat, rsel, issue_en, issue_rd, flush,
        output rdat, rbusy, busy_vec
    );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, write-back clears, flush clears all.
// Priority is flush, then issue, then write-back; bit 0 never becomes busy.
module register_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int NWRITE = 1,
    parameter int NREGS  = NUM_REGS,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 flush,
    input  logic [NWRITE-1:0]    wen,
    input  logic [NWRITE*AW-1:0] wsel,
    output logic [NREGS-1:0]     busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Later assignments override earlier ones, so the code order is the reverse of the priority.
    always_comb begin
        // NOTE: assign the full default first so no path leaves busy_d unassigned (no latch).
        busy_d = busy_q;
        for (int k = 0; k < NWRITE; k++) begin
            if (wen[k] && sel_writable(int'(wsel[k*AW +: AW]), NREGS)) begin
                busy_d[wsel[k*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en && sel_writable(int'(issue_rd), NREGS)) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!nrst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with optional write-to-read bypass and a busy scoreboard.
// Reads are combinational; writes and scoreboard updates take effect on the next rising edge.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int NREGS  = NUM_REGS,
    parameter int DW     = $bits(word_t),
    parameter int AW     = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               nrst,
    register_file_mp_if.slave  bus
);

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [NREGS-1:0] busy_vec;

    logic [NWRITE-1:0] wvalid;
    logic [AW-1:0]     wsel_k [NWRITE];
    logic [DW-1:0]     wdat_k [NWRITE];
    logic [NREGS-1:0]  wdec   [NWRITE];

    // Per-port decode; a port aimed at register 0 or out of range is treated as idle.
    for (genvar k = 0; k < NWRITE; k++) begin : g_wport
        assign wsel_k[k] = bus.wsel[k*AW +: AW];
        assign wdat_k[k] = bus.wdat[k*DW +: DW];
        assign wvalid[k] = bus.wen[k] && sel_writable(int'(wsel_k[k]), NREGS);
        assign wdec[k]   = wvalid[k] ? (NREGS'(1) << wsel_k[k]) : '0;
    end

    // Ascending port order, so the highest-indexed port wins a shared destination.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NWRITE; k++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (wdec[k][r]) begin
                    regs_d[r] = wdat_k[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: the array is reset because reads after reset must return zero.
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    register_scoreboard #(
        .NWRITE (NWRITE),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_scoreboard (
        .clk      (clk),
        .nrst     (nrst),
        .issue_en (bus.issue_en),
        .issue_rd (bus.issue_rd),
        .flush    (bus.flush),
        .wen      (bus.wen),
        .wsel     (bus.wsel),
        .busy_vec (busy_vec)
    );

    assign bus.busy_vec = busy_vec;

    for (genvar i = 0; i < NREAD; i++) begin : g_rport
        logic [AW-1:0] rsel_i;
        logic          in_range;
        logic          hit;
        logic [DW-1:0] byp_dat;
        logic [DW-1:0] stored;
        logic          busy;

        assign rsel_i   = bus.rsel[i*AW +: AW];
        assign in_range = sel_writable(int'(rsel_i), NREGS);
        assign stored   = in_range ? regs_q[rsel_i] : '0;
        assign busy     = in_range && busy_vec[rsel_i];

        // wvalid already excludes register 0, so a zero select never hits.
        always_comb begin
            hit     = 1'b0;
            byp_dat = '0;
            for (int k = 0; k < NWRITE; k++) begin
                if (wvalid[k] && (wsel_k[k] == rsel_i)) begin
                    hit     = 1'b1;
                    byp_dat = wdat_k[k];
                end
            end
        end

        if (BYPASS) begin : g_byp
            assign bus.rdat[i*DW +: DW] = hit ? byp_dat : stored;
            assign bus.rbusy[i]         = busy && !hit;
        end else begin : g_nobyp
            assign bus.rdat[i*DW +: DW] = stored;
            assign bus.rbusy[i]         = busy;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and
// compares both against a spec-level model through an expectation queue.
module tb_register_file_mp;
    import register_file_mp_pkg::*;

    localparam int NREAD  = 3;
    localparam int NWRITE = 2;
    localparam int NREGS  = NUM_REGS;
    localparam int DW     = 32;
    localparam int AW     = $clog2(NREGS);

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    register_file_mp_if #(.NREAD(NREAD), .NWRITE(NWRITE), .NREGS(NREGS), .DW(DW)) bus_b ();
    register_file_mp_if #(.NREAD(NREAD), .NWRITE(NWRITE), .NREGS(NREGS), .DW(DW)) bus_n ();

    register_file_mp #(.NREAD(NREAD), .NWRITE(NWRITE), .NREGS(NREGS), .DW(DW), .BYPASS(1'b1))
        u_dut_byp (.clk(clk), .nrst(nrst), .bus(bus_b));
    register_file_mp #(.NREAD(NREAD), .NWRITE(NWRITE), .NREGS(NREGS), .DW(DW), .BYPASS(1'b0))
        u_dut_nob (.clk(clk), .nrst(nrst), .bus(bus_n));

    typedef struct packed {
        logic [NREAD*DW-1:0] rdat_b;
        logic [NREAD*DW-1:0] rdat_n;
        logic [NREAD-1:0]    rbusy_b;
        logic [NREAD-1:0]    rbusy_n;
        logic [NREGS-1:0]    busy_vec;
    } exp_t;

    exp_t exp_q[$];

    word_t m_regs [NREGS];
    bit    m_busy [NREGS];

    logic [NWRITE-1:0] s_wen;
    regbits_t          s_wsel [NWRITE];
    word_t             s_wdat [NWRITE];
    regbits_t          s_rsel [NREAD];
    logic              s_issue_en;
    regbits_t          s_issue_rd;
    logic              s_flush;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_ctl();
        s_wen      = '0;
        s_issue_en = 1'b0;
        s_issue_rd = '0;
        s_flush    = 1'b0;
        for (int k = 0; k < NWRITE; k++) begin
            s_wsel[k] = '0;
            s_wdat[k] = '0;
        end
    endtask

    task automatic set_write(input int k, input int sel, input word_t dat);
        s_wen[k]  = 1'b1;
        s_wsel[k] = regbits_t'(sel);
        s_wdat[k] = dat;
    endtask

    task automatic set_rsel(input int r0, input int r1, input int r2);
        s_rsel[0] = regbits_t'(r0);
        s_rsel[1] = regbits_t'(r1);
        s_rsel[2] = regbits_t'(r2);
    endtask

    task automatic drive();
        bus_b.wen = s_wen;  bus_n.wen = s_wen;
        for (int k = 0; k < NWRITE; k++) begin
            bus_b.wsel[k*AW +: AW] = s_wsel[k];  bus_n.wsel[k*AW +: AW] = s_wsel[k];
            bus_b.wdat[k*DW +: DW] = s_wdat[k];  bus_n.wdat[k*DW +: DW] = s_wdat[k];
        end
        for (int i = 0; i < NREAD; i++) begin
            bus_b.rsel[i*AW +: AW] = s_rsel[i];  bus_n.rsel[i*AW +: AW] = s_rsel[i];
        end
        bus_b.issue_en = s_issue_en;  bus_n.issue_en = s_issue_en;
        bus_b.issue_rd = s_issue_rd;  bus_n.issue_rd = s_issue_rd;
        bus_b.flush    = s_flush;     bus_n.flush    = s_flush;
    endtask

    // Outputs the spec promises for the current state and the inputs now on the bus.
    function automatic exp_t predict();
        exp_t  e;
        int    r;
        bit    hit;
        word_t d;
        e = '0;
        for (int i = 0; i < NREAD; i++) begin
            r   = int'(s_rsel[i]);
            hit = 1'b0;
            d   = '0;
            for (int k = 0; k < NWRITE; k++) begin
                if (s_wen[k] && int'(s_wsel[k]) == r && r != 0) begin
                    hit = 1'b1;
                    d   = s_wdat[k];
                end
            end
            if (r != 0) begin
                e.rdat_n[i*DW +: DW] = m_regs[r];
                e.rdat_b[i*DW +: DW] = hit ? d : m_regs[r];
                e.rbusy_n[i]         = m_busy[r];
                e.rbusy_b[i]         = m_busy[r] && !hit;
            end
        end
        for (int q = 0; q < NREGS; q++) e.busy_vec[q] = m_busy[q];
        return e;
    endfunction

    // State after the coming rising edge, one register at a time.
    task automatic model_edge();
        bit    written;
        word_t val;
        for (int r = 1; r < NREGS; r++) begin
            written = 1'b0;
            val     = m_regs[r];
            for (int k = 0; k < NWRITE; k++) begin
                if (s_wen[k] && int'(s_wsel[k]) == r) begin
                    written = 1'b1;
                    val     = s_wdat[k];
                end
            end
            m_regs[r] = val;
            if (s_flush)                                      m_busy[r] = 1'b0;
            else if (s_issue_en && int'(s_issue_rd) == r)     m_busy[r] = 1'b1;
            else if (written)                                 m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        exp_q.push_back(predict());
        model_edge();
    endtask

    // Reset for half a cycle; anything on the bus that cycle is lost.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        clear_ctl();
        drive();
        nrst = 1'b0;
        model_clear();
        exp_q.push_back(predict());
        @(negedge clk);
        #1;
        nrst = 1'b1;
    endtask

    function automatic regbits_t rand_sel();
        if ($urandom_range(0, 3) == 0) return regbits_t'($urandom_range(0, NREGS - 1));
        return regbits_t'($urandom_range(0, 7));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NREAD; i++) begin
                    check($sformatf("rdat_byp[%0d]", i), 64'(bus_b.rdat[i*DW +: DW]), 64'(e.rdat_b[i*DW +: DW]));
                    check($sformatf("rdat_nob[%0d]", i), 64'(bus_n.rdat[i*DW +: DW]), 64'(e.rdat_n[i*DW +: DW]));
                    check($sformatf("rbusy_byp[%0d]", i), 64'(bus_b.rbusy[i]), 64'(e.rbusy_b[i]));
                    check($sformatf("rbusy_nob[%0d]", i), 64'(bus_n.rbusy[i]), 64'(e.rbusy_n[i]));
                end
                check("busy_vec_byp", 64'(bus_b.busy_vec), 64'(e.busy_vec));
                check("busy_vec_nob", 64'(bus_n.busy_vec), 64'(e.busy_vec));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        model_clear();
        clear_ctl();
        set_rsel(0, 0, 0);
        drive();
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Reset state, then a write lost to a half-cycle reset.
        set_rsel(1, 5, 31);                         cycle();
        set_write(0, 5, 32'hDEAD_BEEF);             cycle();
        clear_ctl(); set_rsel(5, 5, 5);             reset_pulse();
        cycle();

        // Same-address conflict and writes to register 0.
        set_write(0, 7, 32'h11); set_write(1, 7, 32'h22); set_rsel(7, 0, 7); cycle();
        clear_ctl();                                cycle();
        set_write(0, 0, 32'hFFFF_FFFF); set_write(1, 0, 32'hFFFF_FFFF); set_rsel(0, 7, 0); cycle();
        clear_ctl();                                cycle();

        // Bypass versus stored value.
        set_write(0, 3, 32'hA5A5); set_rsel(3, 7, 3); cycle();
        clear_ctl();                                cycle();

        // Issue, hold, write-back clear.
        s_issue_en = 1'b1; s_issue_rd = 9; set_rsel(9, 3, 0); cycle();
        clear_ctl();                                cycle();
        set_write(1, 9, 32'h9999);                  cycle();
        clear_ctl();                                cycle();

        // Issue beats write-back, flush beats issue, issue of register 0 is a no-op.
        s_issue_en = 1'b1; s_issue_rd = 4; set_write(0, 4, 32'h44); set_rsel(4, 6, 9); cycle();
        clear_ctl();                                cycle();
        s_flush = 1'b1; s_issue_en = 1'b1; s_issue_rd = 6; cycle();
        clear_ctl();                                cycle();
        s_issue_en = 1'b1; s_issue_rd = 0; set_rsel(0, 4, 6); cycle();
        clear_ctl();                                cycle();

        // Randomised traffic with one reset in the middle.
        for (int n = 0; n < 10000; n++) begin
            if (n == 5000) begin
                reset_pulse();
            end
            clear_ctl();
            for (int k = 0; k < NWRITE; k++) begin
                if ($urandom_range(0, 9) < 6) set_write(k, int'(rand_sel()), word_t'($urandom));
            end
            for (int i = 0; i < NREAD; i++) s_rsel[i] = rand_sel();
            s_issue_en = ($urandom_range(0, 2) == 0);
            s_issue_rd = rand_sel();
            s_flush    = ($urandom_range(0, 31) == 0);
            cycle();
        end

        clear_ctl();
        cycle();
        repeat (2) @(negedge clk);
        #1;
        check("expect_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
